// File: rtl/vga_image_fetch.sv
// Read-side image RAM client for the VGA path: maps screen coordinates inside
// a fixed window to a RAM address and shows the fetched pixel. Outside the
// window it shows the background colour. Syncs and active are delayed three
// stages so they line up with the registered pixel.
module vga_image_fetch #(
  parameter int unsigned          AddressWidth  = 14,
  parameter int unsigned          DataWidth     = 8,
  parameter int unsigned          ImgWidthLog2  = 7,
  parameter int unsigned          ImgHeightLog2 = 7,
  parameter int unsigned          ScaleLog2     = 0,
  parameter int unsigned          CountWidth    = 10,
  parameter int unsigned          XOffset       = 256,
  parameter int unsigned          YOffset       = 176,
  parameter logic [DataWidth-1:0] BgColor       = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [CountWidth-1:0]   hcount,
  input  logic [CountWidth-1:0]   vcount,
  input  logic                    active_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  output logic                    ram_rw,
  output logic [AddressWidth-1:0] ram_addr,
  input  logic [DataWidth-1:0]    ram_data,
  output logic [DataWidth-1:0]    rgb,
  output logic                    active_out,
  output logic                    hsync_out,
  output logic                    vsync_out
);

  localparam int unsigned WinW = (2 ** ImgWidthLog2) << ScaleLog2;
  localparam int unsigned WinH = (2 ** ImgHeightLog2) << ScaleLog2;

  // Bounds are one bit wider than the counters, so a window that runs past
  // the last column is clipped instead of wrapping to column 0.
  localparam logic [CountWidth:0] XLo = (CountWidth + 1)'(XOffset);
  localparam logic [CountWidth:0] XHi = (CountWidth + 1)'(XOffset + WinW);
  localparam logic [CountWidth:0] YLo = (CountWidth + 1)'(YOffset);
  localparam logic [CountWidth:0] YHi = (CountWidth + 1)'(YOffset + WinH);

  localparam logic [CountWidth-1:0] XOff = CountWidth'(XOffset);
  localparam logic [CountWidth-1:0] YOff = CountWidth'(YOffset);

  logic [AddressWidth-1:0] ram_addr_q, ram_addr_d;
  logic                    win_d1_q, win_d1_d;
  logic                    win_d2_q, win_d2_d;
  logic [DataWidth-1:0]    rgb_q, rgb_d;
  logic [2:0]              act_sr_q, act_sr_d;
  logic [2:0]              hs_sr_q, hs_sr_d;
  logic [2:0]              vs_sr_q, vs_sr_d;

  logic                     in_win;
  logic [CountWidth-1:0]    dx, dy;
  logic [CountWidth:0]      h_ext, v_ext;
  logic [ImgWidthLog2-1:0]  col;
  logic [ImgHeightLog2-1:0] row;

  // Window test, address mapping and next state of every pipeline stage.
  always_comb begin
    h_ext  = {1'b0, hcount};
    v_ext  = {1'b0, vcount};
    in_win = active_in && (h_ext >= XLo) && (h_ext < XHi) &&
             (v_ext >= YLo) && (v_ext < YHi);
    dx     = hcount - XOff;
    dy     = vcount - YOff;
    col    = ImgWidthLog2'(dx >> ScaleLog2);
    row    = ImgHeightLog2'(dy >> ScaleLog2);

    ram_addr_d = ram_addr_q;
    if (in_win) begin
      ram_addr_d = {row, col};
    end
    win_d1_d = in_win;
    win_d2_d = win_d1_q;
    rgb_d    = win_d2_q ? ram_data : BgColor;
    act_sr_d = {act_sr_q[1:0], active_in};
    hs_sr_d  = {hs_sr_q[1:0], hsync_in};
    vs_sr_d  = {vs_sr_q[1:0], vsync_in};
  end

  // Pipeline registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_addr_q <= '0;
      win_d1_q   <= 1'b0;
      win_d2_q   <= 1'b0;
      rgb_q      <= BgColor;
      act_sr_q   <= '0;
      hs_sr_q    <= '0;
      vs_sr_q    <= '0;
    end else begin
      ram_addr_q <= ram_addr_d;
      win_d1_q   <= win_d1_d;
      win_d2_q   <= win_d2_d;
      rgb_q      <= rgb_d;
      act_sr_q   <= act_sr_d;
      hs_sr_q    <= hs_sr_d;
      vs_sr_q    <= vs_sr_d;
    end
  end

  assign ram_rw     = 1'b1;
  assign ram_addr   = ram_addr_q;
  assign rgb        = rgb_q;
  assign active_out = act_sr_q[2];
  assign hsync_out  = hs_sr_q[2];
  assign vsync_out  = vs_sr_q[2];

endmodule

// File: tb/tb_vga_image_fetch.sv
// Testbench for vga_image_fetch: one instance at scale 1 and one at scale 2,
// each with its own synchronous-read RAM model over a shared image. The
// expected pixel and sync outputs are queued when coordinates are driven and
// compared three edges later.
module tb_vga_image_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  hcount, vcount;
  logic        active_in, hsync_in, vsync_in;

  logic        rw0, rw1;
  logic [13:0] addr0, addr1;
  logic [7:0]  rdata0, rdata1;
  logic [7:0]  rgb0, rgb1;
  logic        act0, act1, hs0, hs1, vs0, vs1;

  logic [7:0]  mem [16384];

  typedef struct packed {
    logic [7:0] rgb0;
    logic [7:0] rgb1;
    logic       act;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_addr0, exp_addr1;

  always #5 clk = ~clk;

  vga_image_fetch dut0 (
    .clk(clk), .rstn(rstn), .hcount(hcount), .vcount(vcount),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ram_rw(rw0), .ram_addr(addr0), .ram_data(rdata0), .rgb(rgb0),
    .active_out(act0), .hsync_out(hs0), .vsync_out(vs0)
  );

  vga_image_fetch #(.ScaleLog2(1)) dut1 (
    .clk(clk), .rstn(rstn), .hcount(hcount), .vcount(vcount),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ram_rw(rw1), .ram_addr(addr1), .ram_data(rdata1), .rgb(rgb1),
    .active_out(act1), .hsync_out(hs1), .vsync_out(vs1)
  );

  // Synchronous-read image RAMs: data one cycle after the address.
  always @(posedge clk) begin
    rdata0 <= mem[addr0];
    rdata1 <= mem[addr1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit model_in(int h, int v, bit a, int s);
    int w = 128 * (1 << s);
    return a && h >= 256 && h < 256 + w && v >= 176 && v < 176 + w;
  endfunction

  function automatic int model_addr(int h, int v, int s);
    return ((v - 176) / (1 << s)) * 128 + (h - 256) / (1 << s);
  endfunction

  // Drive one pixel, advance one edge, then check addresses and any output
  // whose three-edge latency has elapsed.
  task automatic cycle(input int h, input int v, input bit a, input bit hs, input bit vs);
    exp_t e;
    int   na0, na1;
    hcount    = 10'(h);
    vcount    = 10'(v);
    active_in = a;
    hsync_in  = hs;
    vsync_in  = vs;
    na0 = exp_addr0;
    na1 = exp_addr1;
    e.rgb0 = 8'h00;
    e.rgb1 = 8'h00;
    if (model_in(h, v, a, 0)) begin
      na0    = model_addr(h, v, 0);
      e.rgb0 = mem[na0];
    end
    if (model_in(h, v, a, 1)) begin
      na1    = model_addr(h, v, 1);
      e.rgb1 = mem[na1];
    end
    e.act = a;
    e.hs  = hs;
    e.vs  = vs;
    sb.push_back(e);
    @(posedge clk);
    #1;
    exp_addr0 = na0;
    exp_addr1 = na1;
    chk("addr0", 32'(addr0), 32'(exp_addr0));
    chk("addr1", 32'(addr1), 32'(exp_addr1));
    if (sb.size() == 3) begin
      e = sb.pop_front();
      chk("rgb0", 32'(rgb0), 32'(e.rgb0));
      chk("rgb1", 32'(rgb1), 32'(e.rgb1));
      chk("act0", 32'(act0), 32'(e.act));
      chk("hs0",  32'(hs0),  32'(e.hs));
      chk("vs0",  32'(vs0),  32'(e.vs));
      chk("act1", 32'(act1), 32'(e.act));
      chk("hs1",  32'(hs1),  32'(e.hs));
      chk("vs1",  32'(vs1),  32'(e.vs));
    end
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    exp_t z;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_rgb0", 32'(rgb0), 32'h00);
    chk("rst_rgb1", 32'(rgb1), 32'h00);
    chk("rst_act",  32'(act0), 32'h0);
    chk("rst_hs",   32'(hs0),  32'h0);
    chk("rst_vs",   32'(vs0),  32'h0);
    chk("rst_addr0", 32'(addr0), 32'h0);
    chk("rst_addr1", 32'(addr1), 32'h0);
    chk("rst_rw",   32'({rw0, rw1}), 32'h3);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    sb.delete();
    z = '0;
    sb.push_back(z);
    sb.push_back(z);
    exp_addr0 = 0;
    exp_addr1 = 0;
  endtask

  task automatic sweep_line(input int v);
    for (int h = 0; h < 800; h++) begin
      cycle(h, v, (h < 640) && (v < 480), !(h >= 656 && h < 752), !(v >= 490 && v < 492));
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    hcount = '0; vcount = '0; active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    rstn = 1'b1;
    #1;
    do_reset();

    // Origin, corner, just outside, blanked inside, scaled pairs and edges.
    cycle(256, 176, 1, 1, 0);
    cycle(257, 176, 1, 0, 1);
    cycle(383, 303, 1, 1, 1);
    cycle(384, 303, 1, 0, 0);
    cycle(255, 176, 1, 1, 0);
    cycle(300, 200, 0, 0, 1);
    cycle(258, 178, 1, 1, 1);
    cycle(259, 178, 1, 0, 0);
    cycle(511, 431, 1, 1, 0);
    cycle(512, 431, 1, 0, 1);
    cycle(256, 175, 1, 1, 1);
    cycle(0, 0, 0, 0, 0);
    chk("rw", 32'({rw0, rw1}), 32'h3);

    // Partial frame around the window edges and the sync intervals.
    for (int v = 174; v <= 178; v++) sweep_line(v);
    for (int v = 302; v <= 305; v++) sweep_line(v);
    for (int v = 430; v <= 432; v++) sweep_line(v);
    sweep_line(490);

    // Reset in the middle of a window with syncs high, then recover.
    for (int h = 300; h < 310; h++) cycle(h, 250, 1, 1, 1);
    do_reset();
    for (int h = 300; h < 310; h++) cycle(h, 250, 1, 1, 1);
    cycle(383, 303, 1, 1, 1);
    repeat (3) cycle(700, 500, 0, 1, 1);
    chk("rw_end", 32'({rw0, rw1}), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
